// File: rtl/risc32_pkg.sv
// ---------------------------------------------------------------------------
// risc32_pkg
// Shared types and constants for the Risc32 instruction fetch front-end.
//   XLEN / INSTR_W   : architectural address and instruction widths
//   RESET_PC_DEFAULT : default fetch start address after reset
//   fetch_entry_t    : one queued fetch result, {pc, instr}
//   pc_align()       : clears the byte-offset bits of a target address
// ---------------------------------------------------------------------------
package risc32_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two target bits carry no meaning.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch entries with a single-cycle flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the queue at the next edge (wins over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to enqueue
//   pop        : drop the head entry
//   head       : current head entry (valid while count != 0)
//   count      : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = risc32_pkg::fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Defensive guards: the owner never overfills or over-drains.
  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only meaningful below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_store
    always_ff @(posedge clk) begin
      mem_q[gi] <= mem_d[gi];
    end
  end

  // Head is read combinationally so decode sees it in the cycle it lands.
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// ---------------------------------------------------------------------------
// instr_prefetch
// Instruction fetch front-end: issues sequential word reads to a synchronous
// instruction memory, queues returned instructions with their PCs and hands
// them to decode over valid/ready. A redirect flushes the queue, drops the
// read in flight and restarts fetch at the target.
//   clk, rst        : clock, synchronous active-high reset
//   imem_rd_en      : read strobe, data returns one cycle later
//   imem_addr       : word index into instruction memory
//   imem_rdata      : read data for the previous cycle's strobe
//   redirect_valid  : taken branch / jump pulse
//   redirect_pc     : target byte address (bits [1:0] ignored)
//   out_valid/ready : decode handshake
//   out_instr/pc    : head instruction and its byte PC
// Optional build macro PREFETCH_STATS_EN adds saturating counters:
//   stat_flushes    : number of redirects
//   stat_starve     : cycles with out_ready high and out_valid low
// ---------------------------------------------------------------------------
module instr_prefetch
  import risc32_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter int               IMEM_ROWS = 16,
  parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEFAULT,
  localparam int              AW        = $clog2(IMEM_ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]        stat_flushes,
  output logic [15:0]        stat_starve
`endif
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_SPAN = XLEN'(IMEM_ROWS * 4);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;
  logic [INSTR_W-1:0] last_instr_q, last_instr_d;

  logic [CW-1:0]      count;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               credit_ok;
  logic               issue;
  logic               push;
  logic               pop;
  logic               head_valid;

  // Credit uses the registered count only, so a pop this cycle does not
  // open a slot for an issue this cycle. Outstanding read is counted too,
  // which guarantees the response always finds room.
  assign credit_ok  = ({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
  assign issue      = !rst && !redirect_valid && credit_ok;
  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc_q[2 +: AW];

  // A redirect in the response cycle discards the returning word.
  assign push       = inflight_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  assign head_valid = (count != '0);
  assign out_valid  = !rst && head_valid && !redirect_valid;
  assign pop        = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = issue;
    req_pc_d     = req_pc_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;

    if (redirect_valid) begin
      fetch_pc_d = pc_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_d = (fetch_pc_q + 32'd4) % PC_SPAN;
    end

    // The issuing PC rides along with the read so the response can be tagged.
    if (issue) begin
      req_pc_d = fetch_pc_q;
    end

    // Track the head so the outputs hold their last value once the queue empties.
    if (head_valid) begin
      last_pc_d    = head.pc;
      last_instr_d = head.instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      inflight_q   <= 1'b0;
      req_pc_q     <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      req_pc_q     <= req_pc_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

  assign out_instr = rst ? '0 : (head_valid ? head.instr : last_instr_q);
  assign out_pc    = rst ? '0 : (head_valid ? head.pc    : last_pc_q);

`ifdef PREFETCH_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (redirect_valid && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    if (out_ready && !out_valid && (starve_cnt_q != 16'hFFFF)) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign stat_flushes = flush_cnt_q;
  assign stat_starve  = starve_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch
// Directed bench for instr_prefetch with a behavioural synchronous memory and
// a scoreboard of expected {pc, instr} pairs checked on every handshake.
// Build with PREFETCH_STATS_EN defined to also exercise the stat counters.
// ---------------------------------------------------------------------------
module tb_instr_prefetch;

  localparam int DEPTH     = 4;
  localparam int IMEM_ROWS = 16;
  localparam int AW        = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
`ifdef PREFETCH_STATS_EN
  logic [15:0]   stat_flushes;
  logic [15:0]   stat_starve;
`endif

  logic [31:0] mem [IMEM_ROWS];
  exp_t        sb [$];
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  instr_prefetch #(
    .DEPTH     (DEPTH),
    .IMEM_ROWS (IMEM_ROWS),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_flushes   (stat_flushes),
    .stat_starve    (stat_starve)
`endif
  );

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (imem_rd_en === 1'b1) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected stream from a restart point: sequential, wrapping at IMEM_ROWS*4.
  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      sb.push_back('{pc: p, instr: mem[p[5:2]]});
      p = (p + 32'd4) % 32'(IMEM_ROWS * 4);
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected pair.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL sb_empty: observed pc %h expected no handshake", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        $display("pop pc=%h instr=%h", out_pc, out_instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int issues;
    int exp_addr [4];
    exp_addr = '{14, 15, 0, 1};

    for (int i = 0; i < IMEM_ROWS; i++) begin
      mem[i] = (i < 8) ? (32'hA0 + 32'(i)) : (32'hB000_0000 + 32'(i));
    end
    imem_rdata     = '0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // ---- reset state and first fetch latency ----
    repeat (3) tick();
    mid();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    tick();
    rst = 1'b0;
    sb_restart(32'h0);
    mid();
    check("first_rd_en", 32'(imem_rd_en), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    check("first_valid_c0", 32'(out_valid), 32'd0);
    tick();
    mid();
    check("first_valid_c1", 32'(out_valid), 32'd0);
    tick();
    mid();
    check("first_valid_c2", 32'(out_valid), 32'd1);
    repeat (6) tick();

    // ---- back-pressure: exactly DEPTH issues, then gap-free drain ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    sb_restart(32'h0);
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (imem_rd_en === 1'b1) issues++;
      tick();
    end
    check("stall_issues", 32'(issues), 32'(DEPTH));
    mid();
    check("stall_rd_en", 32'(imem_rd_en), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_pc", out_pc, 32'h0);
    check("stall_instr", out_instr, 32'hA0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      check("drain_no_gap", 32'(out_valid), 32'd1);
      tick();
    end

    // ---- redirect while full: three dead cycles, no stale entries ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    repeat (8) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1E;
    out_ready      = 1'b1;
    sb_restart(32'h1C);
    mid();
    check("redir_n_valid", 32'(out_valid), 32'd0);
    check("redir_n_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    mid();
    check("redir_n1_valid", 32'(out_valid), 32'd0);
    check("redir_n1_rd_en", 32'(imem_rd_en), 32'd1);
    check("redir_n1_addr", 32'(imem_addr), 32'd7);
    tick();
    mid();
    check("redir_n2_valid", 32'(out_valid), 32'd0);
    tick();
    mid();
    check("redir_n3_valid", 32'(out_valid), 32'd1);
    check("redir_n3_pc", out_pc, 32'h1C);
    check("redir_n3_instr", out_instr, 32'hA7);
    repeat (4) tick();

    // ---- redirect near the top of memory: address wrap ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h38;
    sb_restart(32'h38);
    mid();
    check("wrap_n_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("wrap_rd_en", 32'(imem_rd_en), 32'd1);
      check("wrap_addr", 32'(imem_addr), 32'(exp_addr[i]));
      tick();
    end
    repeat (4) tick();

    // ---- reset coinciding with a redirect and a pending response ----
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    mid();
    check("rstredir_valid", 32'(out_valid), 32'd0);
    check("rstredir_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    sb_restart(32'h0);
    mid();
    check("rstredir_after_valid", 32'(out_valid), 32'd0);
    check("rstredir_after_rd_en", 32'(imem_rd_en), 32'd1);
    check("rstredir_after_addr", 32'(imem_addr), 32'd0);
`ifdef PREFETCH_STATS_EN
    check("rstredir_flushes", 32'(stat_flushes), 32'd0);
`endif
    tick();
    tick();
    mid();
    check("rstredir_first_valid", 32'(out_valid), 32'd1);
    check("rstredir_first_pc", out_pc, 32'h0);
    repeat (3) tick();

`ifdef PREFETCH_STATS_EN
    // ---- statistics: 3 redirects (last wins) and 5 starved cycles ----
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    repeat (6) tick();
    mid();
    check("stat_starve_idle", 32'(stat_starve), 32'd0);
    tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    sb_restart(32'h10);
    redirect_pc = 32'h08;
    tick();
    redirect_pc = 32'h0C;
    tick();
    redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    mid();
    check("stat_lastwins_valid", 32'(out_valid), 32'd1);
    check("stat_lastwins_pc", out_pc, 32'h10);
    check("stat_flushes_3", 32'(stat_flushes), 32'd3);
    check("stat_starve_5", 32'(stat_starve), 32'd5);
    tick();
    out_ready = 1'b0;
    tick();

    // ---- statistics saturation ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    sb.delete();
    repeat (65540) tick();
    mid();
    check("stat_flushes_sat", 32'(stat_flushes), 32'h0000_FFFF);
    check("stat_starve_sat", 32'(stat_starve), 32'h0000_FFFF);
    tick();
    mid();
    check("stat_flushes_stick", 32'(stat_flushes), 32'h0000_FFFF);
    check("stat_starve_stick", 32'(stat_starve), 32'h0000_FFFF);
    tick();
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    mid();
    check("stat_flushes_clr", 32'(stat_flushes), 32'd0);
    check("stat_starve_clr", 32'(stat_starve), 32'd0);
    rst = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Instruction fetch front-end for the Risc32 core. Sits between instruction memory and the datapath decode stage.
- Issues sequential word reads to the synchronous instruction memory and buffers returned instructions with their PCs in a small queue.
- Serves decode over a valid/ready handshake.
- Branch or jump redirects from the datapath flush the queue, drop any read already in flight, and restart fetch at the target.

Parameters:
- DEPTH, 4, queue entries (power of 2, minimum 2).
- IMEM_ROWS, 16, instruction memory words. The PC wraps modulo IMEM_ROWS*4 bytes.
- RESET_PC, 32'h0, fetch start address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_rd_en  out  1  read strobe; data returns exactly one cycle later
- imem_addr  out  $clog2(IMEM_ROWS)  word index (byte PC >> 2, wrapped)
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en
- redirect_valid  in  1  taken branch or jump (one-cycle pulse)
- redirect_pc  in  32  target byte address; bits [1:0] are ignored
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts the head
- out_instr  out  32  head instruction
- out_pc  out  32  byte PC of the head instruction

Behaviour:
Clock and reset
- One clock, clk. Reset is synchronous and active-high on rst.
- While rst is high at a rising edge:
  - fetch_pc <= RESET_PC; count <= 0; inflight <= 0.
  - Outputs: out_valid=0, imem_rd_en=0, out_instr=0, out_pc=0.
  - First fetch is issued in the first cycle with rst low.
  - rst overrides every other input, including redirect_valid.

Fetch issue
- imem_rd_en=1 when !redirect_valid && (count + inflight) < DEPTH.
- On issue: imem_addr = fetch_pc[2 +: AW], then fetch_pc <= (fetch_pc + 4) mod (IMEM_ROWS*4). The captured PC travels with the request.
- inflight <= 1 when issued this cycle, else 0.
- A pop in the same cycle does not free credit for an issue in that cycle.

Response
- In the cycle after an issue, imem_rdata and the captured PC are pushed into the queue at the clock edge, unless a redirect occurred in that cycle.
- Credit accounting guarantees a push is never made into a full queue.

Output handshake
- out_valid = (count != 0) && !redirect_valid.
- Pop happens on out_valid && out_ready.
- out_instr and out_pc reflect the head and remain stable while out_valid && !out_ready.
- When empty: out_instr and out_pc hold their last values and out_valid=0.

Redirect in cycle N
- Queue count <= 0 and the pending response is discarded.
- No issue in cycle N; any handshake in cycle N is void.
- fetch_pc <= {redirect_pc[31:2], 2'b00}.
- Timing: issue of the target occurs in N+1, and out_valid with out_pc = target first rises in N+3.
- Back-to-back redirects: the last one wins.

Throughput
- Steady state with out_ready=1 is one instruction per cycle.
- Simultaneous push and pop keep count unchanged.

State
- Implicit; no explicit FSM beyond count, inflight, and the redirect discard flag.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined, adds output ports stat_flushes[15:0] and stat_starve[15:0]:
  - stat_flushes counts redirects.
  - stat_starve counts cycles with out_ready=1 and out_valid=0.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package risc32_pkg holds:
  - XLEN=32 and INSTR_W=32.
  - RESET_PC default.
  - A typedef for the fetch entry struct {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch entries with a single-cycle flush input and a count output. Both DEPTH and the entry type are parameterised.

Test Plan:
- Reset release, out_ready=1, memory preloaded with words 0..7 = 32'hA0..A7: out_valid first rises 2 cycles after rst falls; then out_pc 0,4,8,C... with out_instr A0,A1,... one per cycle.
- out_ready=0 for 10 cycles: imem_rd_en stops after 4 issues (count=4). On release, PCs 0..C drain in order with no gaps, then fetch resumes at PC 10.
- Redirect to 32'h1E in cycle N while the queue is full: out_valid=0 in N through N+2; at N+3 out_pc=32'h1C and out_instr=mem[7]. No stale entry (from before the redirect) ever appears.
- IMEM_ROWS=16, redirect to 32'h38: the sequence is 38, 3C, 00, 04; imem_addr is 14, 15, 0, 1.
- rst asserted at the same edge as redirect_valid with a response pending: afterwards out_valid=0 and the first fetch is at RESET_PC. With PREFETCH_STATS_EN defined, stat_flushes=0.
- With PREFETCH_STATS_EN, 3 redirects plus 5 starved cycles give stat_flushes=3 and stat_starve=5. The counters stick at FFFF when forced near saturation.
